// File: rtl/prog_loader.sv
// Program-memory load sequencer: turns a load command plus a word stream into
// single-cycle writes on the programming mux port, with optional broadcast replay.
module prog_loader #(
  parameter int unsigned LOG_CORES   = 2,
  parameter int unsigned PC_WIDTH    = 3,
  parameter int unsigned INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LOG_CORES-1:0]   cmd_core,
  input  logic                   cmd_bcast,
  input  logic [PC_WIDTH-1:0]    cmd_addr,
  input  logic [PC_WIDTH-1:0]    cmd_len,
  input  logic                   abort,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [INSTR_WIDTH-1:0] din_data,
  output logic                   we,
  output logic [LOG_CORES-1:0]   sel,
  output logic [PC_WIDTH-1:0]    waddr,
  output logic [INSTR_WIDTH-1:0] wdata,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {StIdle, StLoad, StBcast} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [PC_WIDTH-1:0]    rem_q, rem_d;
  logic [LOG_CORES-1:0]   core_q, core_d;
  logic                   bcast_q, bcast_d;
  logic [INSTR_WIDTH-1:0] data_q, data_d;
  logic [LOG_CORES-1:0]   cnt_q, cnt_d;
  logic                   we_d, done_d;
  logic [LOG_CORES-1:0]   sel_d;
  logic [PC_WIDTH-1:0]    waddr_d;
  logic [INSTR_WIDTH-1:0] wdata_d;

  assign cmd_ready = (state_q == StIdle);
  assign din_ready = (state_q == StLoad) && !abort;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    core_d  = core_q;
    bcast_d = bcast_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    sel_d   = '0;
    waddr_d = '0;
    wdata_d = '0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            core_d  = cmd_core;
            bcast_d = cmd_bcast;
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = StLoad;
          end
        end
        StLoad: begin
          if (din_valid) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = din_data;
            if (bcast_q) begin
              // Core 0 is written now; cores 1..CORES-1 are replayed from data_q.
              sel_d   = '0;
              data_d  = din_data;
              cnt_d   = LOG_CORES'(1);
              state_d = StBcast;
            end else begin
              sel_d  = core_q;
              addr_d = addr_q + PC_WIDTH'(1);
              if (rem_q == '0) begin
                done_d  = 1'b1;
                state_d = StIdle;
              end else begin
                rem_d = rem_q - PC_WIDTH'(1);
              end
            end
          end
        end
        StBcast: begin
          we_d    = 1'b1;
          sel_d   = cnt_q;
          waddr_d = addr_q;
          wdata_d = data_q;
          if (&cnt_q) begin
            addr_d = addr_q + PC_WIDTH'(1);
            if (rem_q == '0) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              rem_d   = rem_q - PC_WIDTH'(1);
              state_d = StLoad;
            end
          end else begin
            cnt_d = cnt_q + LOG_CORES'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      core_q  <= '0;
      bcast_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      we      <= 1'b0;
      sel     <= '0;
      waddr   <= '0;
      wdata   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      core_q  <= core_d;
      bcast_q <= bcast_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      we      <= we_d;
      sel     <= sel_d;
      waddr   <= waddr_d;
      wdata   <= wdata_d;
      done    <= done_d;
    end
  end

endmodule
